flopr_pipe: RTL and testbench
=============================

FLOPR_PIPE -- requirements
Module: flopr_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 3, number of register stages; SHALL be >= 1.
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit value loaded into every stage's data on reset.
REQ-004 clk_in  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_in  input  1  reset, asynchronous, active-high.
REQ-006 flush  input  1  synchronous clear of all stage valid bits.
REQ-007 d  input  WIDTH  upstream data.
REQ-008 in_valid  input  1  upstream offers d.
REQ-009 in_ready  output  1  block accepts d this cycle.
REQ-010 q  output  WIDTH  data of the last stage (stage DEPTH-1).
REQ-011 out_valid  output  1  valid bit of the last stage.
REQ-012 out_ready  input  1  downstream accepts q.
REQ-013 count  output  $clog2(DEPTH+1)  number of stages currently holding valid data.

Function
REQ-014 Each stage i SHALL hold data[i] (WIDTH bits) and valid[i] (1 bit); stage 0 is the input stage, stage DEPTH-1 drives q/out_valid.
REQ-015 A transfer SHALL occur at the input when in_valid & in_ready, and at the output when out_valid & out_ready.
REQ-016 Stage readiness: rdy[DEPTH-1] = ~valid[DEPTH-1] | out_ready; rdy[i] = ~valid[i] | rdy[i+1] for i < DEPTH-1; combinational ready chain, no bubble insertion.
REQ-017 in_ready SHALL equal rdy[0] & ~flush.
REQ-018 When rdy[i] is high and flush is low, stage i SHALL load data and valid from stage i-1 (stage 0 from d/in_valid); when rdy[i] is low, stage i SHALL hold.
REQ-019 Data of a stage SHALL be captured only when its incoming valid is 1; an invalid bubble shifting in SHALL clear valid but leave data unchanged.
REQ-020 Latency: with out_ready held at 1, a word accepted at rising edge k SHALL appear on q with out_valid = 1 after edge k+DEPTH-1 (DEPTH cycles); sustained throughput SHALL be one word per cycle.
REQ-021 Order SHALL be preserved; no word SHALL be duplicated or dropped except by flush or reset.
REQ-022 Full (all valid[i] = 1, out_ready = 0): in_ready SHALL be 0 and all stages SHALL hold.
REQ-023 Full with out_ready = 1: in_ready SHALL be 1 and a simultaneous input and output transfer SHALL occur, count unchanged.
REQ-024 Empty: out_valid SHALL be 0 and q SHALL show the last stage's held data (not guaranteed meaningful).
REQ-025 Flush high at an edge: all valid[i] SHALL become 0; any output transfer in that cycle SHALL still count as delivered; the input word SHALL NOT be accepted (in_ready = 0); data registers SHALL hold.
REQ-026 count SHALL equal the number of set valid[i] bits, registered, range 0..DEPTH; it SHALL be updated in the same edge as the valid bits.
REQ-027 Outputs q, out_valid and count SHALL be driven only from registers; in_ready is combinational from valid bits, out_ready and flush.

Reset
REQ-028 While rst_in = 1, asynchronously: all valid[i] = 0, all data[i] = RESET_VAL, count = 0, out_valid = 0, q = RESET_VAL.
REQ-029 Reset asserted mid-operation SHALL discard all held words immediately, without waiting for a clock edge.
REQ-030 On the first rising edge after rst_in falls, the block SHALL accept input normally (in_ready = 1 if flush = 0).

Verification
REQ-031 Reset: rst_in = 1 with in_valid = 1, d = 32'hDEADBEEF for 3 edges -> out_valid = 0, q = 32'h0, count = 0, no word later emerges.
REQ-032 Latency (DEPTH = 3): out_ready = 1, send 32'h00000001..32'h00000005 on consecutive edges -> q = 32'h00000001 with out_valid = 1 after the third edge, then one word per cycle in order.
REQ-033 Back-pressure: out_ready = 0, send 32'hA, 32'hB, 32'hC, 32'hD -> count = 3, in_ready = 0 with 32'hD pending; raise out_ready -> outputs A, B, C, D in order, none lost.
REQ-034 Full pass-through: full with out_ready = 1 and in_valid = 1 -> one in and one out per edge, count stays 3.
REQ-035 Flush: pipeline holding 3 words, flush = 1 for one edge with in_valid = 1, d = 32'h55 -> count = 0, out_valid = 0, 32'h55 never emerges.
REQ-036 Parameter sweep: DEPTH = 1, WIDTH = 8, RESET_VAL = 8'hFF -> reset gives q = 8'hFF; latency 1 cycle; REQ-032 to REQ-035 repeated with scaled values pass.

Source files
------------

// File: rtl/flopr_pipe.sv
// flopr_pipe: DEPTH-stage valid/ready register pipeline with synchronous flush.
//
// Each stage holds a data word and a valid bit. Readiness ripples back
// combinationally from the output, so a full pipeline still moves one word per
// cycle when the consumer is ready, and no bubbles are inserted.
//
// Parameters
//   WIDTH     data width in bits (>= 1)
//   DEPTH     number of register stages (>= 1)
//   RESET_VAL value loaded into every stage's data register on reset
//
// Ports
//   clk_in    clock, rising edge
//   rst_in    asynchronous active-high reset
//   flush     synchronous clear of every stage valid bit; blocks input
//   d         upstream data
//   in_valid  upstream offers d
//   in_ready  pipeline accepts d this cycle (combinational)
//   q         data of the last stage (registered)
//   out_valid valid bit of the last stage (registered)
//   out_ready downstream accepts q
//   count     number of stages holding valid data (registered)

module flopr_pipe #(
  parameter int unsigned         WIDTH     = 32,
  parameter int unsigned         DEPTH     = 3,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [WIDTH-1:0] w_din  [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] w_valid_nxt;
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_vin;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;

  // Stage i is ready unless it and every stage after it are valid while the
  // consumer stalls. Computed as a running AND from the tail so the ready
  // vector never feeds back into itself.
  always_comb begin : p_ready
    logic w_all_valid;
    w_all_valid = 1'b1;
    w_rdy       = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      w_all_valid = w_all_valid & r_valid[i];
      w_rdy[i]    = ~w_all_valid | out_ready;
    end
  end

  // Per-stage upstream source and data registers.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign w_vin[g] = in_valid;
      assign w_din[g] = d;
    end else begin : g_body
      assign w_vin[g] = r_valid[g-1];
      assign w_din[g] = r_data[g-1];
    end

    // Data only moves with a valid word; bubbles leave the old data in place.
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        r_data[g] <= RESET_VAL;
      end else if (w_rdy[g] && !flush && w_vin[g]) begin
        r_data[g] <= w_din[g];
      end
    end
  end

  // Next valid bits and their population count, so count lands on the same
  // edge as the valid bits it describes.
  always_comb begin
    w_valid_nxt = r_valid;
    w_count_nxt = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (flush) begin
        w_valid_nxt[i] = 1'b0;
      end else if (w_rdy[i]) begin
        w_valid_nxt[i] = w_vin[i];
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_count_nxt = w_count_nxt + CW'(w_valid_nxt[i]);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign in_ready  = w_rdy[0] & ~flush;
  assign q         = r_data[DEPTH-1];
  assign out_valid = r_valid[DEPTH-1];
  assign count     = r_count;

endmodule

// File: tb/tb_flopr_pipe.sv
// tb_flopr_pipe: directed bench for flopr_pipe. Two instances share the clock
// and reset: dut A (WIDTH 32, DEPTH 3, RESET_VAL 0) and dut B (WIDTH 8,
// DEPTH 1, RESET_VAL 8'hFF). Scenario tasks take a selector (0 = A, 1 = B).

module tb_flopr_pipe;

  logic        clk_in = 1'b0;
  logic        rst_in;

  logic        a_flush, a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_d, a_q;
  logic [1:0]  a_cnt;

  logic        b_flush, b_iv, b_ir, b_ov, b_or;
  logic [7:0]  b_d, b_q;
  logic [0:0]  b_cnt;

  int n_pass  = 0;
  int n_total = 0;

  flopr_pipe #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'h0)) u_dut_a (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .flush    (a_flush),
    .d        (a_d),
    .in_valid (a_iv),
    .in_ready (a_ir),
    .q        (a_q),
    .out_valid(a_ov),
    .out_ready(a_or),
    .count    (a_cnt)
  );

  flopr_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'hFF)) u_dut_b (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .flush    (b_flush),
    .d        (b_d),
    .in_valid (b_iv),
    .in_ready (b_ir),
    .q        (b_q),
    .out_valid(b_ov),
    .out_ready(b_or),
    .count    (b_cnt)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] get_q(input bit sel);
    return sel ? {24'h0, b_q} : a_q;
  endfunction

  function automatic logic get_ov(input bit sel);
    return sel ? b_ov : a_ov;
  endfunction

  function automatic logic get_ir(input bit sel);
    return sel ? b_ir : a_ir;
  endfunction

  function automatic logic [31:0] get_cnt(input bit sel);
    return sel ? {31'h0, b_cnt} : {30'h0, a_cnt};
  endfunction

  function automatic int depth_of(input bit sel);
    return sel ? 1 : 3;
  endfunction

  function automatic logic [31:0] rv_of(input bit sel);
    return sel ? 32'hFF : 32'h0;
  endfunction

  task automatic set_in(input bit sel, input logic iv, input logic [31:0] dat,
                        input logic ordy, input logic fl);
    if (sel) begin
      b_iv = iv; b_d = dat[7:0]; b_or = ordy; b_flush = fl;
    end else begin
      a_iv = iv; a_d = dat;      a_or = ordy; a_flush = fl;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reset held over three edges with a word offered; nothing may be captured.
  task automatic test_reset();
    rst_in = 1'b1;
    for (int s = 0; s < 2; s++) set_in(bit'(s), 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    repeat (3) tick();
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (get_ov(bit'(s)) !== 1'b0) $display("FAIL reset_ov dut%0d: got %b want 0", s, get_ov(bit'(s)));
      else n_pass++;
      n_total++;
      if (get_q(bit'(s)) !== rv_of(bit'(s)))
        $display("FAIL reset_q dut%0d: got %h want %h", s, get_q(bit'(s)), rv_of(bit'(s)));
      else n_pass++;
      n_total++;
      if (get_cnt(bit'(s)) !== 32'd0) $display("FAIL reset_cnt dut%0d: got %0d want 0", s, get_cnt(bit'(s)));
      else n_pass++;
      set_in(bit'(s), 1'b0, 32'h0, 1'b1, 1'b0);
    end
    rst_in = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (get_ir(bit'(s)) !== 1'b1) $display("FAIL reset_ready dut%0d: got %b want 1", s, get_ir(bit'(s)));
      else n_pass++;
    end
    for (int e = 0; e < 5; e++) begin
      tick();
      for (int s = 0; s < 2; s++) begin
        n_total++;
        if (get_ov(bit'(s)) !== 1'b0) $display("FAIL reset_leak dut%0d edge %0d: got %b want 0", s, e, get_ov(bit'(s)));
        else n_pass++;
      end
    end
  endtask

  // Words 1..5 back to back; word j shows after edge j+DEPTH-1, leaves at j+DEPTH.
  task automatic test_latency(input bit sel);
    int dep;
    int wj;
    int exp_cnt;
    bit exp_ov;
    dep = depth_of(sel);
    for (int n = 1; n <= 5 + dep; n++) begin
      set_in(sel, (n <= 5), 32'(n), 1'b1, 1'b0);
      tick();
      wj      = n - dep + 1;
      exp_ov  = (wj >= 1) && (wj <= 5);
      exp_cnt = ((n < 5) ? n : 5) - ((n > dep) ? n - dep : 0);
      n_total++;
      if (get_ov(sel) !== exp_ov) $display("FAIL lat_ov dut%0d edge %0d: got %b want %b", sel, n, get_ov(sel), exp_ov);
      else n_pass++;
      if (exp_ov) begin
        n_total++;
        if (get_q(sel) !== 32'(wj)) $display("FAIL lat_q dut%0d edge %0d: got %h want %h", sel, n, get_q(sel), wj);
        else n_pass++;
      end
      n_total++;
      if (get_cnt(sel) !== 32'(exp_cnt))
        $display("FAIL lat_cnt dut%0d edge %0d: got %0d want %0d", sel, n, get_cnt(sel), exp_cnt);
      else n_pass++;
    end
    set_in(sel, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  // Fill with the consumer stalled, then release and score deliveries in order.
  task automatic test_backpressure(input bit sel);
    logic [31:0] w [4];
    int dep;
    int k;
    int nxt;
    w[0] = 32'hA; w[1] = 32'hB; w[2] = 32'hC; w[3] = 32'hD;
    dep = depth_of(sel);
    for (int j = 0; j < dep; j++) begin
      set_in(sel, 1'b1, w[j], 1'b0, 1'b0);
      #1;
      n_total++;
      if (get_ir(sel) !== 1'b1) $display("FAIL bp_fill_ready dut%0d word %0d: got %b want 1", sel, j, get_ir(sel));
      else n_pass++;
      tick();
      n_total++;
      if (get_cnt(sel) !== 32'(j + 1)) $display("FAIL bp_fill_cnt dut%0d: got %0d want %0d", sel, get_cnt(sel), j + 1);
      else n_pass++;
    end
    set_in(sel, 1'b1, w[dep], 1'b0, 1'b0);
    #1;
    n_total++;
    if (get_ir(sel) !== 1'b0) $display("FAIL bp_full_ready dut%0d: got %b want 0", sel, get_ir(sel));
    else n_pass++;
    tick();
    n_total++;
    if (get_cnt(sel) !== 32'(dep)) $display("FAIL bp_hold_cnt dut%0d: got %0d want %0d", sel, get_cnt(sel), dep);
    else n_pass++;
    n_total++;
    if (get_q(sel) !== w[0] || get_ov(sel) !== 1'b1)
      $display("FAIL bp_hold_q dut%0d: got %h/%b want %h/1", sel, get_q(sel), get_ov(sel), w[0]);
    else n_pass++;
    k   = 0;
    nxt = dep;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      set_in(sel, (nxt < 4), w[(nxt < 4) ? nxt : 0], 1'b1, 1'b0);
      #1;
      if (get_ov(sel) === 1'b1) begin
        n_total++;
        if (get_q(sel) !== w[k]) $display("FAIL bp_order dut%0d idx %0d: got %h want %h", sel, k, get_q(sel), w[k]);
        else n_pass++;
        k++;
      end
      if (nxt < 4 && get_ir(sel) === 1'b1) nxt++;
      tick();
    end
    n_total++;
    if (k != 4) $display("FAIL bp_delivered dut%0d: got %0d words want 4", sel, k);
    else n_pass++;
    n_total++;
    if (get_cnt(sel) !== 32'd0) $display("FAIL bp_drain_cnt dut%0d: got %0d want 0", sel, get_cnt(sel));
    else n_pass++;
    set_in(sel, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  // Full pipeline, consumer ready: one in and one out per edge, count constant.
  task automatic test_full_passthrough(input bit sel);
    logic [31:0] s [8];
    int dep;
    dep = depth_of(sel);
    for (int j = 0; j < dep; j++) s[j] = 32'h10 + 32'(j);
    for (int j = 0; j < 4; j++) s[dep + j] = 32'h20 + 32'(j);
    for (int j = 0; j < dep; j++) begin
      set_in(sel, 1'b1, s[j], 1'b0, 1'b0);
      tick();
    end
    n_total++;
    if (get_cnt(sel) !== 32'(dep)) $display("FAIL pt_fill_cnt dut%0d: got %0d want %0d", sel, get_cnt(sel), dep);
    else n_pass++;
    for (int e = 1; e <= 4; e++) begin
      set_in(sel, 1'b1, 32'h20 + 32'(e - 1), 1'b1, 1'b0);
      #1;
      n_total++;
      if (get_ir(sel) !== 1'b1) $display("FAIL pt_ready dut%0d edge %0d: got %b want 1", sel, e, get_ir(sel));
      else n_pass++;
      tick();
      n_total++;
      if (get_cnt(sel) !== 32'(dep)) $display("FAIL pt_cnt dut%0d edge %0d: got %0d want %0d", sel, e, get_cnt(sel), dep);
      else n_pass++;
      n_total++;
      if (get_ov(sel) !== 1'b1 || get_q(sel) !== s[e])
        $display("FAIL pt_q dut%0d edge %0d: got %h/%b want %h/1", sel, e, get_q(sel), get_ov(sel), s[e]);
      else n_pass++;
    end
  endtask

  // Flush a full pipeline while offering 0x55; data registers must hold.
  task automatic test_flush(input bit sel);
    int dep;
    logic [31:0] hold;
    dep  = depth_of(sel);
    hold = 32'h20 + 32'(4 - dep);
    set_in(sel, 1'b1, 32'h55, 1'b1, 1'b1);
    #1;
    n_total++;
    if (get_ir(sel) !== 1'b0) $display("FAIL flush_ready dut%0d: got %b want 0", sel, get_ir(sel));
    else n_pass++;
    tick();
    n_total++;
    if (get_cnt(sel) !== 32'd0) $display("FAIL flush_cnt dut%0d: got %0d want 0", sel, get_cnt(sel));
    else n_pass++;
    n_total++;
    if (get_ov(sel) !== 1'b0) $display("FAIL flush_ov dut%0d: got %b want 0", sel, get_ov(sel));
    else n_pass++;
    set_in(sel, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int e = 0; e < dep + 2; e++) begin
      tick();
      n_total++;
      if (get_ov(sel) !== 1'b0) $display("FAIL flush_leak dut%0d edge %0d: got %b want 0", sel, e, get_ov(sel));
      else n_pass++;
    end
    n_total++;
    if (get_q(sel) !== hold) $display("FAIL flush_q_hold dut%0d: got %h want %h", sel, get_q(sel), hold);
    else n_pass++;
  endtask

  // Reset asserted between edges must clear immediately, then input resumes.
  task automatic test_async_reset();
    for (int j = 0; j < 2; j++) begin
      for (int s = 0; s < 2; s++) set_in(bit'(s), 1'b1, 32'h60 + 32'(j), 1'b0, 1'b0);
      tick();
    end
    for (int s = 0; s < 2; s++) set_in(bit'(s), 1'b0, 32'h0, 1'b0, 1'b0);
    n_total++;
    if (a_cnt !== 2'd2) $display("FAIL areset_pre_cnt dut0: got %0d want 2", a_cnt);
    else n_pass++;
    rst_in = 1'b1;
    #2;
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (get_ov(bit'(s)) !== 1'b0 || get_cnt(bit'(s)) !== 32'd0 || get_q(bit'(s)) !== rv_of(bit'(s)))
        $display("FAIL areset_clear dut%0d: got ov %b cnt %0d q %h want 0 0 %h", s, get_ov(bit'(s)),
                 get_cnt(bit'(s)), get_q(bit'(s)), rv_of(bit'(s)));
      else n_pass++;
    end
    tick();
    rst_in = 1'b0;
    for (int s = 0; s < 2; s++) set_in(bit'(s), 1'b1, 32'h77, 1'b1, 1'b0);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (get_ir(bit'(s)) !== 1'b1) $display("FAIL areset_ready dut%0d: got %b want 1", s, get_ir(bit'(s)));
      else n_pass++;
    end
    tick();
    for (int s = 0; s < 2; s++) begin
      n_total++;
      if (get_cnt(bit'(s)) !== 32'd1) $display("FAIL areset_accept dut%0d: got %0d want 1", s, get_cnt(bit'(s)));
      else n_pass++;
      set_in(bit'(s), 1'b0, 32'h0, 1'b1, 1'b0);
    end
    repeat (4) tick();
  endtask

  initial begin
    rst_in = 1'b1;
    set_in(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    set_in(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    test_reset();
    for (int s = 0; s < 2; s++) begin
      test_latency(bit'(s));
      test_backpressure(bit'(s));
      test_full_passthrough(bit'(s));
      test_flush(bit'(s));
    end
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
